// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-master UART register-port arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    // UART wb_we convention: 0 = write, 1 = read
    localparam logic WE_WRITE = 1'b0;
    localparam logic WE_READ  = 1'b1;

    localparam logic [1:0] TX_DATA_ADDR  = 2'b00;
    localparam logic [1:0] RX_DATA_ADDR  = 2'b01;
    localparam logic [1:0] FREQ_DIV_ADDR = 2'b10;

    // Read data returned to a master whose slave cycle timed out
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // One master's request bundle as seen by the arbiter
    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       we;
    } wb_req_t;

endpackage

// File: rtl/uart_arb_rr2.sv
// Two-requester round-robin picker. Purely combinational: on a tie the
// requester that did not win last time is chosen.
// last_grant: 0 = requester 0 won last, 1 = requester 1 won last.
module uart_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // One-hot pick from the live requests and the previous owner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Two-master / one-slave arbiter for the UART 8-bit register port.
// Whole strobe/ack transactions are serialised with round-robin fairness;
// read data and ack are returned only to the granted master.
// Optional slave-ack timeout: define UART_WB_ARBITER_TIMEOUT_EN.
module uart_wb_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] m0_addr,
    input  logic [7:0] m0_wdata,
    input  logic       m0_we,
    input  logic       m0_stb,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic [1:0] m1_addr,
    input  logic [7:0] m1_wdata,
    input  logic       m1_we,
    input  logic       m1_stb,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic [1:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_we,
    output logic       s_stb,
    input  logic [7:0] s_rdata,
    input  logic       s_ack,
    output logic [1:0] grant,
    output logic       timeout_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("uart_wb_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    arb_state_t state;
    logic       last_grant;   // 0 = m0 owned the last transaction, 1 = m1
    logic [1:0] pick;
    logic       own_stb;
    logic       to_hit;
    wb_req_t    req0, req1, sel_req;

    assign req0    = '{addr: m0_addr, wdata: m0_wdata, we: m0_we};
    assign req1    = '{addr: m1_addr, wdata: m1_wdata, we: m1_we};
    assign sel_req = pick[1] ? req1 : req0;

    // Strobe of whichever master currently owns the slave
    assign own_stb = grant[1] ? m1_stb : m0_stb;

    uart_arb_rr2 u_rr (
        .req        ({m1_stb, m0_stb}),
        .last_grant (last_grant),
        .gnt        (pick)
    );

`ifdef UART_WB_ARBITER_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_err_q;

    // Fires on the last allowed BUSY cycle if the slave still has not acked
    assign to_hit = (state == ST_BUSY) && !s_ack &&
                    (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    // BUSY-cycle counter; held at zero outside BUSY so it starts clean
    always_ff @(posedge clk) begin
        if (!reset || state != ST_BUSY) to_cnt <= 8'd0;
        else                            to_cnt <= to_cnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset)      to_err_q <= 1'b0;
        else if (to_hit) to_err_q <= 1'b1;
    end

    assign timeout_err = to_err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Transaction FSM; every master/slave-facing output is registered here
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;          // m0 wins the first tie
            grant      <= 2'b00;
            s_addr     <= 2'b00;
            s_wdata    <= 8'h00;
            s_we       <= WE_WRITE;
            s_stb      <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= 8'h00;
            m1_rdata   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        s_addr     <= sel_req.addr;
                        s_wdata    <= sel_req.wdata;
                        s_we       <= sel_req.we;
                        s_stb      <= 1'b1;
                        grant      <= pick;
                        last_grant <= pick[1];
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (s_ack || to_hit) begin
                        s_stb <= 1'b0;
                        if (own_stb) begin
                            if (grant[0]) begin
                                m0_ack <= 1'b1;
                                if (s_we == WE_READ)
                                    m0_rdata <= s_ack ? s_rdata : TIMEOUT_RDATA;
                            end else begin
                                m1_ack <= 1'b1;
                                if (s_we == WE_READ)
                                    m1_rdata <= s_ack ? s_rdata : TIMEOUT_RDATA;
                            end
                            state <= ST_DONE;
                        end else begin
                            // Master abandoned the cycle: finish it silently
                            grant <= 2'b00;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DONE: begin
                    if (!own_stb) begin
                        m0_ack <= 1'b0;
                        m1_ack <= 1'b0;
                        grant  <= 2'b00;
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Never start a new strobe while the old ack is still up
                    if (!s_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter. The slave side is driven by hand,
// step by step, with expected values worked out per cycle.
module tb_uart_wb_arbiter;
    import uart_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] m0_addr, m1_addr, s_addr, grant;
    logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic       m0_we, m1_we, m0_stb, m1_stb, m0_ack, m1_ack;
    logic       s_we, s_stb, s_ack, timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    uart_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_stb(m0_stb),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_stb(m1_stb),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_stb(s_stb),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one edge; sample and drive 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] rr_grant [4];
    logic [1:0] rr_addr  [4];

    initial begin
        rr_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_addr  = '{RX_DATA_ADDR, 2'b11, RX_DATA_ADDR, 2'b11};

        reset = 1'b0;
        m0_addr = 2'b00; m0_wdata = 8'h00; m0_we = WE_WRITE; m0_stb = 1'b0;
        m1_addr = 2'b00; m1_wdata = 8'h00; m1_we = WE_WRITE; m1_stb = 1'b0;
        s_rdata = 8'h00; s_ack = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_s_stb", s_stb, 0);
        check("rst_grant", grant, 0);
        check("rst_acks", {m0_ack, m1_ack}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        check("rst_s_addr", {s_addr, s_wdata, s_we}, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b1;

        // m0 write freq divider = 0x06, slave acks the cycle after s_stb
        m0_addr = FREQ_DIV_ADDR; m0_wdata = 8'h06; m0_we = WE_WRITE; m0_stb = 1'b1;
        tick();
        check("w_s_stb", s_stb, 1);
        check("w_grant", grant, 2'b01);
        check("w_s_bus", {s_addr, s_wdata, s_we}, {2'd2, 8'h06, 1'b0});
        check("w_ack_early", m0_ack, 0);
        s_ack = 1'b1;
        tick();
        check("w_m0_ack", m0_ack, 1);
        check("w_s_stb_drop", s_stb, 0);
        check("w_m1_ack", m1_ack, 0);
        s_ack = 1'b0; m0_stb = 1'b0;
        tick();
        check("w_ack_release", {m0_ack, grant}, 0);
        tick();

        // m1 read RX, slave returns 0x5A
        m1_addr = RX_DATA_ADDR; m1_we = WE_READ; m1_stb = 1'b1;
        tick();
        check("r_grant", grant, 2'b10);
        check("r_s_bus", {s_addr, s_we, s_stb}, {2'd1, 1'b1, 1'b1});
        s_rdata = 8'h5A; s_ack = 1'b1;
        tick();
        check("r_m1_ack", m1_ack, 1);
        check("r_m1_rdata", m1_rdata, 8'h5A);
        check("r_m0_rdata", m0_rdata, 8'h00);
        check("r_m0_ack", m0_ack, 0);
        s_ack = 1'b0; m1_stb = 1'b0;
        tick(); tick();

        // Round robin: both masters request continuously (reads)
        m0_addr = RX_DATA_ADDR; m0_we = WE_READ; m0_stb = 1'b1;
        m1_addr = 2'b11;        m1_we = WE_READ; m1_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr%0d_grant", i), grant, rr_grant[i]);
            check($sformatf("rr%0d_addr", i), s_addr, rr_addr[i]);
            s_rdata = 8'h10 + 8'(i); s_ack = 1'b1;
            tick();
            if (rr_grant[i] == 2'b01) begin
                check($sformatf("rr%0d_ack", i), {m0_ack, m1_ack}, 2'b10);
                check($sformatf("rr%0d_rdata", i), m0_rdata, 8'h10 + 8'(i));
                m0_stb = 1'b0;
            end else begin
                check($sformatf("rr%0d_ack", i), {m0_ack, m1_ack}, 2'b01);
                check($sformatf("rr%0d_rdata", i), m1_rdata, 8'h10 + 8'(i));
                m1_stb = 1'b0;
            end
            s_ack = 1'b0;
            tick();
            if (i < 3) begin
                m0_stb = 1'b1; m1_stb = 1'b1;
            end else begin
                m0_stb = 1'b0; m1_stb = 1'b0;
            end
            tick();
        end
        check("rr_m0_rdata_hold", m0_rdata, 8'h12);
        check("rr_m1_rdata_hold", m1_rdata, 8'h13);

        // Write leaves m0_rdata unchanged
        m0_addr = TX_DATA_ADDR; m0_wdata = 8'hA5; m0_we = WE_WRITE; m0_stb = 1'b1;
        tick();
        check("tx_s_bus", {s_addr, s_wdata, s_we}, {2'd0, 8'hA5, 1'b0});
        s_rdata = 8'hEE; s_ack = 1'b1;
        tick();
        check("tx_ack", m0_ack, 1);
        check("tx_rdata_kept", m0_rdata, 8'h12);
        s_ack = 1'b0; m0_stb = 1'b0;
        tick(); tick();

        // m0 abandons its cycle while BUSY
        m0_addr = FREQ_DIV_ADDR; m0_wdata = 8'h11; m0_we = WE_WRITE; m0_stb = 1'b1;
        tick();
        check("ab_grant", grant, 2'b01);
        m0_stb = 1'b0;
        tick(); tick();
        check("ab_s_stb_held", s_stb, 1);
        s_ack = 1'b1;
        tick();
        check("ab_no_ack", {m0_ack, m1_ack}, 0);
        check("ab_drain", {s_stb, grant}, 0);
        tick();
        check("ab_drain_hold", {s_stb, grant}, 0);
        m1_addr = TX_DATA_ADDR; m1_wdata = 8'h3C; m1_we = WE_WRITE; m1_stb = 1'b1;
        s_ack = 1'b0;
        tick();
        check("ab_not_yet", grant, 0);
        tick();
        check("ab_m1_grant", {grant, s_wdata}, {2'b10, 8'h3C});
        s_ack = 1'b1;
        tick();
        check("ab_m1_ack", {m0_ack, m1_ack}, 2'b01);
        s_ack = 1'b0; m1_stb = 1'b0;
        tick(); tick();

        // Reset while BUSY aborts; m0 wins the first tie afterwards
        m1_addr = RX_DATA_ADDR; m1_we = WE_READ; m1_stb = 1'b1;
        tick();
        check("rb_busy", {grant, s_stb}, {2'b10, 1'b1});
        reset = 1'b0;
        m0_addr = TX_DATA_ADDR; m0_wdata = 8'h77; m0_we = WE_WRITE; m0_stb = 1'b1;
        tick();
        check("rb_abort", {s_stb, grant, m0_ack, m1_ack}, 0);
        reset = 1'b1;
        tick();
        check("rb_m0_first", grant, 2'b01);
        s_ack = 1'b1;
        tick();
        check("rb_m0_ack", {m0_ack, m1_ack}, 2'b10);
        s_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
        tick(); tick();

`ifdef UART_WB_ARBITER_TIMEOUT_EN
        // Slave never acks an m0 read: timeout after 4 BUSY cycles
        m0_addr = RX_DATA_ADDR; m0_we = WE_READ; m0_stb = 1'b1;
        tick();
        check("to_busy", grant, 2'b01);
        tick(); tick(); tick();
        check("to_not_yet", {m0_ack, timeout_err}, 0);
        tick();
        check("to_ack", m0_ack, 1);
        check("to_rdata", m0_rdata, TIMEOUT_RDATA);
        check("to_err", timeout_err, 1);
        m0_stb = 1'b0;
        tick(); tick(); tick();
        check("to_err_sticky", timeout_err, 1);
        reset = 1'b0;
        tick();
        check("to_err_clear", timeout_err, 0);
        reset = 1'b1;
`else
        check("to_tied_low", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_arbiter.md
Name: uart_wb_arbiter

Overview:
- Two-master, one-slave arbiter for the UART's 8-bit Wishbone-style register port (TX 0x0, RX 0x1, freq divider 0x2).
- Sits between the UART slave and two requesters: m0 (CPU) and m1 (debug/loader).
- Serialises whole strobe/ack transactions with round-robin fairness.
- Captures slave read data and returns ack only to the granted master.

Parameters:
- TIMEOUT_CYCLES, 255, slave-ack wait limit in clk cycles; used only with the optional feature; range 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- m0_addr  in  2  master 0 register address
- m0_wdata  in  8  master 0 write data
- m0_we  in  1  master 0 direction: 0 = write, 1 = read (UART convention)
- m0_stb  in  1  master 0 strobe; held until m0_ack
- m0_ack  out  1  master 0 acknowledge
- m0_rdata  out  8  read data to master 0
- m1_addr, m1_wdata, m1_we, m1_stb, m1_ack, m1_rdata: same widths and meanings for master 1
- s_addr  out  2  to UART wb_addr
- s_wdata  out  8  to UART wb_data_in
- s_we  out  1  to UART wb_we
- s_stb  out  1  to UART wb_stb
- s_rdata  in  8  from UART wb_data_out
- s_ack  in  1  from UART wb_ack
- grant  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  sticky slave-timeout flag

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge): state=IDLE; all acks, s_stb, grant, timeout_err = 0; s_addr, s_wdata, m*_rdata = 0; s_we=0; last_grant=m1 (so m0 wins the first tie).
- Reset mid-transaction aborts immediately: s_stb drops the next edge and no ack is issued.
- State IDLE:
  - Sample m0_stb and m1_stb.
  - Only one high: grant it.
  - Both high: grant the master not in last_grant.
  - On grant: latch that master's addr/wdata/we onto s_*; s_stb=1; set grant; set last_grant; go to BUSY.
  - s_stb rises 1 edge after the edge that samples the request.
- State BUSY:
  - Hold s_* stable until s_ack==1.
  - On s_ack: s_stb=0; if the read direction was latched (we==1), capture s_rdata into the granted master's rdata; assert the granted master's ack; go to DONE.
  - Minimum request-to-ack latency is 2 edges when the slave acks on the edge after s_stb.
  - If the granted master drops stb before ack (protocol violation): the slave cycle still completes, the master ack is suppressed, and the state goes to DRAIN.
- State DONE: hold ack until the granted master's stb==0; then ack=0, grant=00, go to DRAIN.
- State DRAIN: wait s_ack==0, then go to IDLE. Prevents overlapping a new s_stb with a stale slave ack.
- A back-to-back request from the same master with the other master idle is allowed: it is re-granted from IDLE.
- A non-granted master's ack stays 0 and its rdata holds its last value.
- Writes leave rdata unchanged.
- Unmapped addresses (0x3) are forwarded unchanged; the slave acks them.

Optional Feature:
- Macro: UART_WB_ARBITER_TIMEOUT_EN.
- Enabled:
  - 8-bit counter cleared on entering BUSY, incremented each BUSY cycle.
  - Count reaching TIMEOUT_CYCLES without s_ack: s_stb=0; granted master gets ack with rdata=8'hFF (reads only); timeout_err=1 (sticky until reset); go to DONE.
- Disabled: BUSY waits indefinitely; timeout_err is tied to 0; no counter logic.

Decomposition:
- Shared package uart_arb_pkg:
  - State encoding IDLE/BUSY/DONE/DRAIN (2-bit).
  - WE_WRITE=1'b0, WE_READ=1'b1.
  - UART address constants TX_DATA_ADDR=2'b00, RX_DATA_ADDR=2'b01, FREQ_DIV_ADDR=2'b10.
  - TIMEOUT_RDATA=8'hFF.
- Sub-module uart_arb_rr2: 2-requester round-robin picker. Combinational grant from (req[1:0], last_grant); the only natural split.

Test Plan:
- m0 write addr 0x2 data 0x06, slave acks 1 cycle after s_stb -> s_addr=2, s_wdata=0x06, s_we=0; m0_ack 2 edges after request; m1_ack stays 0.
- m1 read addr 0x1, slave returns 0x5A with ack -> m1_rdata=0x5A with m1_ack; m0_rdata unchanged.
- Both stb high in the same cycle, repeated 4 times with each master re-requesting immediately -> grants alternate m0,m1,m0,m1 starting with m0 after reset.
- m0 drops stb while BUSY, slave acks 3 cycles later -> no m0_ack; state passes through DRAIN to IDLE; the next m1 request is granted normally.
- reset=0 asserted in BUSY with s_stb=1 -> next edge: s_stb=0, grant=00, all acks 0; the first request after release wins per last_grant=m1 (m0 first).
- UART_WB_ARBITER_TIMEOUT_EN with TIMEOUT_CYCLES=4, slave never acks, m0 read -> after 4 BUSY cycles m0_ack=1, m0_rdata=0xFF, timeout_err=1 held until reset.
